// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command controller: FSM states, frame header,
// unit-select encodings and status-byte layout.
package alu_cmd_pkg;

    typedef enum logic [3:0] {
        IDLE,
        GET_A0,
        GET_A1,
        GET_B0,
        GET_B1,
        GET_FUN,
        EXEC,
        SEND0,
        SEND1,
        SEND2
    } state_t;

    localparam logic [7:0] CMD_HDR_DEF = 8'hCC;

    // alu_fun[3:2] picks which unit's result is reported
    localparam logic [1:0] SEL_ARITH = 2'b00;
    localparam logic [1:0] SEL_LOGIC = 2'b01;
    localparam logic [1:0] SEL_CMP   = 2'b10;
    localparam logic [1:0] SEL_SHIFT = 2'b11;

    localparam int STAT_FLAG_BIT  = 0;
    localparam int STAT_CARRY_BIT = 1;

    function automatic logic [7:0] make_status(input logic carry, input logic flag);
        logic [7:0] s;
        s                 = '0;
        s[STAT_CARRY_BIT] = carry;
        s[STAT_FLAG_BIT]  = flag;
        return s;
    endfunction

endpackage

// File: rtl/alu_cmd_tx_ser.sv
// Three-byte result serializer: result low, result high, status, over valid/ready.
// load_i starts a burst; tx_data_o holds steady while tx_valid_o is high and tx_ready_i is low.
module alu_cmd_tx_ser (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] res_dat_i,
    input  logic [7:0]  status_i,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic        accept_o
);

    logic [7:0] hi_q;
    logic [7:0] st_q;
    logic [1:0] idx_q;
    logic [7:0] tx_data_q;
    logic       tx_valid_q;

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign accept_o   = tx_valid_q && tx_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q       <= '0;
            st_q       <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else if (load_i) begin
            hi_q       <= res_dat_i[15:8];
            st_q       <= status_i;
            idx_q      <= 2'd0;
            tx_data_q  <= res_dat_i[7:0];
            tx_valid_q <= 1'b1;
        end else if (tx_valid_q && tx_ready_i) begin
            case (idx_q)
                2'd0: begin
                    tx_data_q <= hi_q;
                    idx_q     <= 2'd1;
                end
                2'd1: begin
                    tx_data_q <= st_q;
                    idx_q     <= 2'd2;
                end
                default: begin
                    tx_data_q  <= '0;
                    tx_valid_q <= 1'b0;
                    idx_q      <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Byte-framed ALU command controller: parses CC/A/B/FUN frames, drives the ALU, returns result+status.
// Optional partial-frame timeout is enabled by defining ALU_CMD_TIMEOUT_EN; ALU_LAT must be >= 1.
module alu_cmd_ctrl
    import alu_cmd_pkg::*;
#(
    parameter int         DATA_WIDTH  = 16,
    parameter int         SEL_LINE    = 4,
    parameter logic [7:0] CMD_HDR     = CMD_HDR_DEF,
    parameter int         ALU_LAT     = 1,
    parameter int         TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [SEL_LINE-1:0]   alu_fun,
    input  logic [DATA_WIDTH-1:0] arith_out,
    input  logic                  arith_flag,
    input  logic                  carry_out,
    input  logic [DATA_WIDTH-1:0] logic_out,
    input  logic                  logic_flag,
    input  logic [DATA_WIDTH-1:0] cmp_out,
    input  logic                  cmp_flag,
    input  logic [DATA_WIDTH-1:0] shift_out,
    input  logic                  shift_flag,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  drop_err
);

    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t                  state_q;
    logic [7:0]              a_lo_q, a_hi_q, b_lo_q, b_hi_q;
    logic [DATA_WIDTH-1:0]   alu_a_q, alu_b_q;
    logic [SEL_LINE-1:0]     alu_fun_q;
    logic                    drop_q;
    logic [LAT_W-1:0]        lat_cnt_q;

    logic                    is_get;
    logic                    lat_done;
    logic                    ser_load;
    logic                    tx_accept;
    logic                    to_expire;
    logic [DATA_WIDTH-1:0]   res_dat;
    logic                    res_flag;
    logic                    res_carry;

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_fun  = alu_fun_q;
    assign drop_err = drop_q;
    assign busy     = (state_q != IDLE);

    assign is_get   = (state_q inside {GET_A0, GET_A1, GET_B0, GET_B1, GET_FUN});
    assign lat_done = (lat_cnt_q == LAT_W'(ALU_LAT - 1));
    assign ser_load = (state_q == EXEC) && lat_done;

`ifdef ALU_CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d  = '0;
        to_expire = 1'b0;
        if (is_get && !rx_valid) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                to_expire = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_expire = 1'b0;
`endif

    // Units are sampled from the registered alu_fun, so selection is stable through EXEC
    always_comb begin
        res_dat   = arith_out;
        res_flag  = arith_flag;
        res_carry = 1'b0;
        case (alu_fun_q[3:2])
            SEL_ARITH: begin
                res_dat   = arith_out;
                res_flag  = arith_flag;
                res_carry = carry_out;
            end
            SEL_LOGIC: begin
                res_dat  = logic_out;
                res_flag = logic_flag;
            end
            SEL_CMP: begin
                res_dat  = cmp_out;
                res_flag = cmp_flag;
            end
            default: begin
                res_dat  = shift_out;
                res_flag = shift_flag;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_lo_q    <= '0;
            a_hi_q    <= '0;
            b_lo_q    <= '0;
            b_hi_q    <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_fun_q <= '0;
            drop_q    <= 1'b0;
            lat_cnt_q <= '0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_valid && (rx_data == CMD_HDR)) state_q <= GET_A0;
                end
                GET_A0: begin
                    if (rx_valid) begin
                        a_lo_q  <= rx_data;
                        state_q <= GET_A1;
                    end else if (to_expire) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b1;
                    end
                end
                GET_A1: begin
                    if (rx_valid) begin
                        a_hi_q  <= rx_data;
                        state_q <= GET_B0;
                    end else if (to_expire) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b1;
                    end
                end
                GET_B0: begin
                    if (rx_valid) begin
                        b_lo_q  <= rx_data;
                        state_q <= GET_B1;
                    end else if (to_expire) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b1;
                    end
                end
                GET_B1: begin
                    if (rx_valid) begin
                        b_hi_q  <= rx_data;
                        state_q <= GET_FUN;
                    end else if (to_expire) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b1;
                    end
                end
                GET_FUN: begin
                    if (rx_valid) begin
                        alu_a_q   <= DATA_WIDTH'({a_hi_q, a_lo_q});
                        alu_b_q   <= DATA_WIDTH'({b_hi_q, b_lo_q});
                        alu_fun_q <= rx_data[SEL_LINE-1:0];
                        lat_cnt_q <= '0;
                        state_q   <= EXEC;
                    end else if (to_expire) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b1;
                    end
                end
                EXEC: begin
                    drop_q <= rx_valid;
                    if (lat_done) begin
                        state_q <= SEND0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + LAT_W'(1);
                    end
                end
                SEND0: begin
                    drop_q <= rx_valid;
                    if (tx_accept) state_q <= SEND1;
                end
                SEND1: begin
                    drop_q <= rx_valid;
                    if (tx_accept) state_q <= SEND2;
                end
                SEND2: begin
                    drop_q <= rx_valid;
                    if (tx_accept) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    alu_cmd_tx_ser u_tx_ser (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ser_load),
        .res_dat_i  (16'(res_dat)),
        .status_i   (make_status(res_carry, res_flag)),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .accept_o   (tx_accept)
    );

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 16, operand and result width.
- SEL_LINE, 4, ALU function select width.
- CMD_HDR, 8'hCC, frame header byte.
- ALU_LAT, 1, clock cycles from operand drive to valid ALU outputs.
- TIMEOUT_CYC, 255, idle cycles after which a partial frame is aborted.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous reset, active-high.
- rx_data, in, 8, received byte.
- rx_valid, in, 1, one-cycle strobe qualifying rx_data.
- alu_a, out, DATA_WIDTH, ALU operand A.
- alu_b, out, DATA_WIDTH, ALU operand B.
- alu_fun, out, SEL_LINE, ALU function select.
- arith_out, in, DATA_WIDTH; arith_flag, in, 1; carry_out, in, 1: arithmetic unit result.
- logic_out, in, DATA_WIDTH; logic_flag, in, 1: logic unit result.
- cmp_out, in, DATA_WIDTH; cmp_flag, in, 1: compare unit result.
- shift_out, in, DATA_WIDTH; shift_flag, in, 1: shift unit result.
- tx_data, out, 8, byte to transmitter.
- tx_valid, out, 1, tx_data valid.
- tx_ready, in, 1, transmitter accepts the byte.
- busy, out, 1, high in every state except IDLE.
- drop_err, out, 1, one-cycle pulse when an rx byte is discarded.

Function
REQ-003 The frame SHALL be: CMD_HDR, A[7:0], A[15:8], B[7:0], B[15:8], FUN (low nibble used, high nibble ignored).
REQ-004 FSM states SHALL be IDLE, GET_A0, GET_A1, GET_B0, GET_B1, GET_FUN, EXEC, SEND0, SEND1, SEND2.
REQ-005 IDLE SHALL advance to GET_A0 only when rx_valid is high and rx_data equals CMD_HDR; any other byte SHALL be silently ignored, with no drop_err.
REQ-006 Each GET_* state SHALL capture rx_data on rx_valid and advance one state; without rx_valid it SHALL hold.
REQ-007 On FUN capture, alu_a, alu_b and alu_fun SHALL update on the same edge and hold until the next frame's FUN capture.
REQ-008 EXEC SHALL count ALU_LAT cycles, then latch a 16-bit result plus flag selected by alu_fun[3:2]:
- 00: arith_out, with carry_out captured.
- 01: logic_out.
- 10: cmp_out.
- 11: shift_out.
REQ-009 The status byte SHALL be {6'b0, carry, flag}; carry SHALL be 0 for non-arithmetic selections.
REQ-010 SEND0, SEND1 and SEND2 SHALL present result[7:0], result[15:8] and the status byte respectively, with tx_valid high.
REQ-011 Each SEND state SHALL advance only on tx_valid && tx_ready; tx_data SHALL be stable while tx_valid is high and tx_ready is low.
REQ-012 After SEND2 is accepted the FSM SHALL return to IDLE; back-to-back frames SHALL be accepted with no extra gap.
REQ-013 rx_valid during EXEC or any SEND state SHALL discard the byte and pulse drop_err in the following cycle.
REQ-014 rx_valid coincident with a state transition SHALL be evaluated against the current (pre-edge) state.
REQ-015 The result path (FUN capture to SEND0 tx_valid) SHALL have a latency of exactly ALU_LAT+1 cycles.

Reset
REQ-016 When rst is high at a clock edge, the FSM SHALL enter IDLE and all outputs SHALL become 0, including alu_a, alu_b, alu_fun, tx_data, tx_valid, busy and drop_err.
REQ-017 Reset mid-frame or mid-send SHALL abandon the frame with no further tx_valid.

Configuration
REQ-018 With ALU_CMD_TIMEOUT_EN defined, a counter SHALL run in GET_* states and clear on each rx_valid.
REQ-019 Under ALU_CMD_TIMEOUT_EN, when the counter reaches TIMEOUT_CYC the FSM SHALL return to IDLE and pulse drop_err once, leaving alu_* outputs unchanged.
REQ-020 Without ALU_CMD_TIMEOUT_EN, no counter SHALL be synthesized and GET_* states SHALL wait indefinitely.

Structure
REQ-021 A shared package alu_cmd_pkg SHALL hold the FSM state enumeration, the CMD_HDR default, the unit-select encodings (00/01/10/11) and the status-byte bit positions.
REQ-022 One sub-module, alu_cmd_tx_ser, SHALL implement the three-byte tx_valid/tx_ready serializer; all other logic stays in alu_cmd_ctrl.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Frame CC 0A 00 05 00 00 with ALU_LAT=1 -> alu_a=10, alu_b=5, alu_fun=0; tx bytes 0F, 00, 00.
- Frame A=FFFE, B=0002, FUN=0 -> tx 00, 00, 02 (carry set).
- Frame A=10, B=10, FUN=9 with cmp_out=1 and cmp_flag=1 from the ALU model -> tx 01, 00, 01; carry bit 0.
- tx_ready held low for 5 cycles in SEND1 -> tx_data=00 stable and tx_valid high throughout; no byte lost.
- Byte 55 in IDLE ignored with no drop_err; byte during SEND0 -> drop_err one-cycle pulse; rst asserted in GET_B0 -> all outputs 0 on the next edge, then the next frame is processed normally.
- With ALU_CMD_TIMEOUT_EN: header then silence for 255 cycles -> IDLE plus a drop_err pulse; without the macro, the FSM remains in GET_A0.
